// File: rtl/score_display_pkg.sv
// Shared types and helpers for the seven-segment score display:
// conversion FSM states, digit count and the BCD-to-segment lookup.
package score_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles render blank.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/score_display_bin2bcd.sv
// Sequential double-dabble converter: one shift per cycle, WIDTH shifts,
// then the four BCD digits are published together in the DONE state.
module bin2bcd
    import score_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] puan,
    output logic             busy,
    output logic [15:0]      bcd
);

    localparam int SR_W  = 16 + WIDTH;
    localparam int CNT_W = 4;

    conv_state_e      state_r, state_s;
    logic [SR_W-1:0]  sr_r, sr_s, adj_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [15:0]      bcd_r, bcd_s;

    // Add-3 correction on every BCD nibble that would overflow on the next shift.
    always_comb begin
        adj_s = sr_r;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sr_r[WIDTH + 4*k +: 4] >= 4'd5) begin
                adj_s[WIDTH + 4*k +: 4] = sr_r[WIDTH + 4*k +: 4] + 4'd3;
            end else begin
                adj_s[WIDTH + 4*k +: 4] = sr_r[WIDTH + 4*k +: 4];
            end
        end
    end

    // Conversion next-state and datapath.
    always_comb begin
        state_s = state_r;
        sr_s    = sr_r;
        cnt_s   = cnt_r;
        bcd_s   = bcd_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    sr_s    = {16'b0, puan};
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                sr_s  = {adj_s[SR_W-2:0], 1'b0};
                cnt_s = cnt_r + 4'd1;
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                bcd_s   = sr_r[WIDTH +: 16];
                state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Conversion state registers.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_r <= IDLE;
            sr_r    <= {SR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            bcd_r   <= 16'h0000;
        end else begin
            state_r <= state_s;
            sr_r    <= sr_s;
            cnt_r   <= cnt_s;
            bcd_r   <= bcd_s;
        end
    end

    assign busy = (state_r != IDLE);
    assign bcd  = bcd_r;

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed seven-segment score display (active-low pins).
// Optional build macro SCORE_DISPLAY_BLANK_EN blanks leading zero digits.
module score_display
    import score_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic [WIDTH-1:0] puan_i,
    output logic [6:0]       seg_o,
    output logic             dp_o,
    output logic [3:0]       an_o,
    output logic             busy_o
);

    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [WIDTH-1:0] last_r;
    logic             start_s;
    logic             busy_s;
    logic [15:0]      bcd_s;
    logic [REF_W-1:0] ref_cnt_r;
    logic [1:0]       idx_r;
    logic [3:0]       an_r;
    logic [6:0]       seg_r;
    logic [3:0]       digit_s;
    logic             lead_zero_s;
    logic [6:0]       seg_next_s;

    // Changes arriving mid-conversion are caught here once the converter idles.
    assign start_s = !busy_s && (puan_i != last_r);

    bin2bcd #(.WIDTH(WIDTH)) u_bin2bcd (
        .clk_i (clk_i),
        .reset (reset),
        .start (start_s),
        .puan  (puan_i),
        .busy  (busy_s),
        .bcd   (bcd_s)
    );

    // Last sampled score for change detection.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            last_r <= {WIDTH{1'b0}};
        end else if (start_s) begin
            last_r <= puan_i;
        end else begin
            last_r <= last_r;
        end
    end

    // Segment pattern for the digit about to be lit.
    always_comb begin
        digit_s     = bcd_s[4*idx_r +: 4];
        lead_zero_s = 1'b0;
`ifdef SCORE_DISPLAY_BLANK_EN
        case (idx_r)
            2'd3:    lead_zero_s = (bcd_s[15:12] == 4'd0);
            2'd2:    lead_zero_s = (bcd_s[15:8]  == 8'd0);
            2'd1:    lead_zero_s = (bcd_s[15:4]  == 12'd0);
            default: lead_zero_s = 1'b0;
        endcase
`else
        lead_zero_s = 1'b0;
`endif
        if (lead_zero_s) begin
            seg_next_s = SEG_BLANK;
        end else begin
            seg_next_s = digit_to_seg(digit_s);
        end
    end

    // Refresh counter, digit index and registered anode/segment drive.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            ref_cnt_r <= {REF_W{1'b0}};
            idx_r     <= 2'd0;
            an_r      <= 4'b1111;
            seg_r     <= SEG_BLANK;
        end else if (ref_cnt_r == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt_r <= {REF_W{1'b0}};
            idx_r     <= idx_r + 2'd1;
            an_r      <= ~(4'b0001 << idx_r);
            seg_r     <= seg_next_s;
        end else begin
            ref_cnt_r <= ref_cnt_r + {{(REF_W-1){1'b0}}, 1'b1};
        end
    end

    assign seg_o  = seg_r;
    assign an_o   = an_r;
    assign dp_o   = 1'b1;
    assign busy_o = busy_s;

endmodule

// File: tb/tb_score_display.sv
// Directed self-checking bench for score_display (WIDTH=6, REFRESH_DIV=4).
module tb_score_display;

    localparam int WIDTH = 6;
    localparam int RD    = 4;

`ifdef SCORE_DISPLAY_BLANK_EN
    localparam logic [6:0] HI_ZERO = 7'b1111111;
`else
    localparam logic [6:0] HI_ZERO = 7'b1000000;
`endif

    logic             clk_i = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] puan_i = '0;
    logic [6:0]       seg_o;
    logic             dp_o;
    logic [3:0]       an_o;
    logic             busy_o;

    int checks = 0;
    int errors = 0;

    score_display #(.WIDTH(WIDTH), .REFRESH_DIV(RD)) dut (
        .clk_i  (clk_i),
        .reset  (reset),
        .puan_i (puan_i),
        .seg_o  (seg_o),
        .dp_o   (dp_o),
        .an_o   (an_o),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Waits for an_o to switch into the given slot (next lighting of that anode).
    task automatic wait_slot(input int idx, output bit to);
        logic [3:0] target;
        logic [3:0] prev;
        target = ~(4'b0001 << idx);
        prev   = an_o;
        to     = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (an_o == target && prev != target) begin
                to = 1'b0;
                break;
            end
            prev = an_o;
        end
    endtask

    // Applies a new score and counts the cycles busy_o stays high.
    task automatic do_conv(input logic [WIDTH-1:0] v, output int cnt);
        puan_i = v;
        step();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy_o) break;
            cnt++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (seg_o !== 7'b1111111) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", seg_o); end
        checks++; if (an_o !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=1111", an_o); end
        checks++; if (dp_o !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_refresh();
        logic [3:0] exp_an;
        reset = 1'b0;
        step(); step(); step();
        checks++; if (an_o !== 4'b1111) begin errors++; $display("FAIL refresh_pre got=%b exp=1111", an_o); end
        step();
        checks++; if (an_o !== 4'b1110) begin errors++; $display("FAIL refresh_first_an got=%b exp=1110", an_o); end
        checks++; if (seg_o !== 7'b1000000) begin errors++; $display("FAIL refresh_first_seg got=%b exp=1000000", seg_o); end
        for (int k = 1; k < 16; k++) begin
            step();
            exp_an = ~(4'b0001 << (k / 4));
            checks++; if (an_o !== exp_an) begin errors++; $display("FAIL refresh_an k=%0d got=%b exp=%b", k, an_o, exp_an); end
            checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL refresh_busy k=%0d got=%b exp=0", k, busy_o); end
            if (k % 4 == 0) begin
                checks++; if (seg_o !== HI_ZERO) begin errors++; $display("FAIL refresh_hi_seg k=%0d got=%b exp=%b", k, seg_o, HI_ZERO); end
            end
        end
    endtask

    task automatic test_conv42();
        int cnt;
        bit to;
        do_conv(6'd42, cnt);
        checks++; if (cnt != WIDTH + 1) begin errors++; $display("FAIL conv42_busy_len got=%0d exp=%0d", cnt, WIDTH + 1); end
        wait_slot(0, to);
        checks++; if (to || seg_o !== 7'b0100100) begin errors++; $display("FAIL conv42_d0 got=%b exp=0100100 timeout=%0d", seg_o, to); end
        wait_slot(1, to);
        checks++; if (to || seg_o !== 7'b0011001) begin errors++; $display("FAIL conv42_d1 got=%b exp=0011001 timeout=%0d", seg_o, to); end
        wait_slot(2, to);
        checks++; if (to || seg_o !== HI_ZERO) begin errors++; $display("FAIL conv42_d2 got=%b exp=%b timeout=%0d", seg_o, HI_ZERO, to); end
        wait_slot(3, to);
        checks++; if (to || seg_o !== HI_ZERO) begin errors++; $display("FAIL conv42_d3 got=%b exp=%b timeout=%0d", seg_o, HI_ZERO, to); end
    endtask

    task automatic test_back_to_back();
        int cnt;
        bit to;
        do_conv(6'd10, cnt);
        checks++; if (cnt != WIDTH + 1) begin errors++; $display("FAIL b2b_first_len got=%0d exp=%0d", cnt, WIDTH + 1); end
        puan_i = 6'd11;
        step();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_start got=%b exp=1", busy_o); end
        step(); step();
        puan_i = 6'd12;
        for (int i = 0; i < 5; i++) step();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_gap got=%b exp=0", busy_o); end
        step();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_restart got=%b exp=1", busy_o); end
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!busy_o) begin to = 1'b0; break; end
            step();
        end
        checks++; if (to) begin errors++; $display("FAIL b2b_settle got=busy exp=idle"); end
        wait_slot(0, to);
        checks++; if (to || seg_o !== 7'b0100100) begin errors++; $display("FAIL b2b_d0 got=%b exp=0100100 timeout=%0d", seg_o, to); end
        wait_slot(1, to);
        checks++; if (to || seg_o !== 7'b1111001) begin errors++; $display("FAIL b2b_d1 got=%b exp=1111001 timeout=%0d", seg_o, to); end
    endtask

    task automatic test_reset_mid();
        bit to;
        puan_i = 6'd25;
        step();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rmid_start got=%b exp=1", busy_o); end
        step(); step(); step();
        reset = 1'b1;
        step();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy_o); end
        checks++; if (seg_o !== 7'b1111111) begin errors++; $display("FAIL rmid_seg got=%b exp=1111111", seg_o); end
        checks++; if (an_o !== 4'b1111) begin errors++; $display("FAIL rmid_an got=%b exp=1111", an_o); end
        reset = 1'b0;
        step();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rmid_resample got=%b exp=1", busy_o); end
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!busy_o) begin to = 1'b0; break; end
            step();
        end
        checks++; if (to) begin errors++; $display("FAIL rmid_settle got=busy exp=idle"); end
        wait_slot(0, to);
        checks++; if (to || seg_o !== 7'b0010010) begin errors++; $display("FAIL rmid_d0 got=%b exp=0010010 timeout=%0d", seg_o, to); end
        wait_slot(1, to);
        checks++; if (to || seg_o !== 7'b0100100) begin errors++; $display("FAIL rmid_d1 got=%b exp=0100100 timeout=%0d", seg_o, to); end
    endtask

    task automatic test_wrap();
        int cnt;
        bit to;
        do_conv(6'd63, cnt);
        checks++; if (cnt != WIDTH + 1) begin errors++; $display("FAIL max_len got=%0d exp=%0d", cnt, WIDTH + 1); end
        wait_slot(0, to);
        checks++; if (to || seg_o !== 7'b0110000) begin errors++; $display("FAIL max_d0 got=%b exp=0110000 timeout=%0d", seg_o, to); end
        wait_slot(1, to);
        checks++; if (to || seg_o !== 7'b0000010) begin errors++; $display("FAIL max_d1 got=%b exp=0000010 timeout=%0d", seg_o, to); end
        wait_slot(2, to);
        checks++; if (to || seg_o !== HI_ZERO) begin errors++; $display("FAIL max_d2 got=%b exp=%b timeout=%0d", seg_o, HI_ZERO, to); end
        wait_slot(3, to);
        checks++; if (to || seg_o !== HI_ZERO) begin errors++; $display("FAIL max_d3 got=%b exp=%b timeout=%0d", seg_o, HI_ZERO, to); end
        do_conv(6'd0, cnt);
        checks++; if (cnt != WIDTH + 1) begin errors++; $display("FAIL wrap_len got=%0d exp=%0d", cnt, WIDTH + 1); end
        wait_slot(0, to);
        checks++; if (to || seg_o !== 7'b1000000) begin errors++; $display("FAIL wrap_d0 got=%b exp=1000000 timeout=%0d", seg_o, to); end
        wait_slot(1, to);
        checks++; if (to || seg_o !== HI_ZERO) begin errors++; $display("FAIL wrap_d1 got=%b exp=%b timeout=%0d", seg_o, HI_ZERO, to); end
        wait_slot(3, to);
        checks++; if (to || seg_o !== HI_ZERO) begin errors++; $display("FAIL wrap_d3 got=%b exp=%b timeout=%0d", seg_o, HI_ZERO, to); end
    endtask

    initial begin
        test_reset();
        test_refresh();
        test_conv42();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
